johnson_phase_decoder: RTL and testbench

JOHNSON_PHASE_DECODER -- requirements
Module: johnson_phase_decoder

---
 rtl/johnson_phase_decoder.sv | 132 +++++++++++++
 tb/tb_johnson_phase_decoder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/johnson_phase_decoder.sv
// rtl/johnson_phase_decoder.sv - Johnson-code phase decoder with step checking, lock FSM and counters
module johnson_phase_decoder #(
  parameter int LOCK_N = 8,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [3:0]       q_in,
  input  logic             clr_err,
  output logic [2:0]       phase,
  output logic [7:0]       strobe,
  output logic             valid,
  output logic             illegal,
  output logic             skip,
  output logic             locked,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {UNLOCKED, LOCKING, LOCKED} state_t;

  state_t     state, state_nxt;
  logic [3:0] good_cnt, good_cnt_nxt;
  logic       have_p;
  logic       code_ok;
  logic [2:0] code_idx;
  logic       accept, is_illegal, is_hold, is_good, is_skip, wrap_step;

  always_comb begin
    code_ok  = 1'b1;
    code_idx = 3'd0;
    case (q_in)
      4'b0000: code_idx = 3'd0;
      4'b0001: code_idx = 3'd1;
      4'b0011: code_idx = 3'd2;
      4'b0111: code_idx = 3'd3;
      4'b1111: code_idx = 3'd4;
      4'b1110: code_idx = 3'd5;
      4'b1100: code_idx = 3'd6;
      4'b1000: code_idx = 3'd7;
      default: code_ok  = 1'b0;
    endcase
  end

  // Step classification only applies once a previous legal phase has been stored.
  always_comb begin
    accept     = en && code_ok;
    is_illegal = en && !code_ok;
    is_hold    = accept && have_p && (code_idx == phase);
    is_good    = accept && have_p && (code_idx == phase + 3'd1);
    is_skip    = accept && have_p && !is_hold && !is_good;
    wrap_step  = is_good && (state == LOCKED) && (code_idx == 3'd0);
  end

  always_comb begin
    state_nxt    = state;
    good_cnt_nxt = good_cnt;
    if (is_illegal) begin
      state_nxt    = UNLOCKED;
      good_cnt_nxt = 4'd0;
    end else if (accept) begin
      case (state)
        UNLOCKED: state_nxt = LOCKING;
        LOCKING: begin
          if (is_skip) begin
            good_cnt_nxt = 4'd0;
          end else if (is_good) begin
            if (good_cnt == 4'(LOCK_N - 1)) begin
              state_nxt    = LOCKED;
              good_cnt_nxt = 4'd0;
            end else begin
              good_cnt_nxt = good_cnt + 4'd1;
            end
          end
        end
        LOCKED: begin
          if (is_skip) begin
            state_nxt    = LOCKING;
            good_cnt_nxt = 4'd0;
          end
        end
        default: state_nxt = UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= UNLOCKED;
      good_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_cnt_nxt;
    end
  end

  assign locked = (state == LOCKED);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase       <= 3'd0;
      strobe      <= 8'd0;
      valid       <= 1'b0;
      illegal     <= 1'b0;
      skip        <= 1'b0;
      have_p      <= 1'b0;
      err_count   <= '0;
      cycle_count <= '0;
    end else begin
      valid   <= accept;
      illegal <= is_illegal;
      skip    <= is_skip;
      strobe  <= accept ? (8'b1 << code_idx) : 8'd0;
      if (accept) begin
        phase  <= code_idx;
        have_p <= 1'b1;
      end else if (is_illegal) begin
        have_p <= 1'b0;
      end
      if (clr_err) begin
        err_count <= '0;
      end else if ((is_illegal || is_skip) && !(&err_count)) begin
        err_count <= err_count + 1'b1;
      end
      if (wrap_step) begin
        cycle_count <= cycle_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// tb/tb_johnson_phase_decoder.sv - randomized self-checking bench with a behavioural phase/lock model
module tb_johnson_phase_decoder;

  localparam int LOCK_N = 8;
  localparam int CNT_W  = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [3:0]       q_in;
  logic             clr_err;
  logic [2:0]       phase;
  logic [7:0]       strobe;
  logic             valid, illegal, skip, locked;
  logic [CNT_W-1:0] err_count, cycle_count;

  johnson_phase_decoder #(.LOCK_N(LOCK_N), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .en(en), .q_in(q_in), .clr_err(clr_err),
    .phase(phase), .strobe(strobe), .valid(valid), .illegal(illegal), .skip(skip),
    .locked(locked), .err_count(err_count), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  logic [3:0] codes [8] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

  int n_checks = 0;
  int n_fail   = 0;

  int         m_phase, m_streak, m_err, m_cycle;
  bit         m_have, m_locked, m_valid, m_illegal, m_skip;
  logic [7:0] m_strobe;

  task automatic model_reset();
    m_phase = 0; m_streak = 0; m_err = 0; m_cycle = 0;
    m_have = 0; m_locked = 0; m_valid = 0; m_illegal = 0; m_skip = 0;
    m_strobe = 8'd0;
  endtask

  // Behavioural view: a sample either establishes the phase, holds, advances by one, or jumps.
  task automatic model_step(input bit e, input logic [3:0] q, input bit c);
    int idx;
    bit bump;
    idx = -1;
    bump = 0;
    m_valid = 0; m_illegal = 0; m_skip = 0; m_strobe = 8'd0;
    if (e) begin
      for (int k = 0; k < 8; k++) if (codes[k] == q) idx = k;
      if (idx < 0) begin
        m_illegal = 1; m_have = 0; m_locked = 0; m_streak = 0; bump = 1;
      end else begin
        m_valid = 1;
        m_strobe = 8'd1 << idx;
        if (m_have && idx != m_phase) begin
          if (idx == (m_phase + 1) % 8) begin
            if (m_locked) begin
              if (idx == 0) m_cycle = (m_cycle + 1) % 256;
            end else begin
              m_streak++;
              if (m_streak == LOCK_N) begin
                m_locked = 1;
                m_streak = 0;
              end
            end
          end else begin
            m_skip = 1; m_locked = 0; m_streak = 0; bump = 1;
          end
        end
        m_phase = idx;
        m_have = 1;
      end
    end
    if (c) m_err = 0;
    else if (bump && m_err < 255) m_err++;
  endtask

  function automatic logic [30:0] dut_vec();
    return {phase, strobe, valid, illegal, skip, locked, err_count, cycle_count};
  endfunction

  function automatic logic [30:0] model_vec();
    return {3'(m_phase), m_strobe, m_valid, m_illegal, m_skip, m_locked, 8'(m_err), 8'(m_cycle)};
  endfunction

  task automatic step(input bit e, input logic [3:0] q, input bit c);
    en = e; q_in = q; clr_err = c;
    @(posedge clk);
    #1;
    model_step(e, q, c);
  endtask

  task automatic test_reset();
    en = 0; q_in = 4'h0; clr_err = 0;
    @(negedge clk) reset = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (dut_vec() !== 31'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h want 0", dut_vec());
    end
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_walk_lock();
    for (int s = 0; s < 17; s++) begin
      step(1, codes[s % 8], 0);
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL walk s=%0d: got %h want %h", s, dut_vec(), model_vec());
      end
      n_checks++;
      if (strobe !== (8'd1 << (s % 8))) begin
        n_fail++;
        $display("FAIL walk_strobe s=%0d: got %h want %h", s, strobe, 8'd1 << (s % 8));
      end
      if (s == 7 || s == 8) begin
        n_checks++;
        if (locked !== (s == 8)) begin
          n_fail++;
          $display("FAIL lock_after_n s=%0d: got %b want %b", s, locked, s == 8);
        end
      end
      if (s == 15 || s == 16) begin
        n_checks++;
        if (cycle_count !== ((s == 16) ? 8'd1 : 8'd0)) begin
          n_fail++;
          $display("FAIL cycle_count s=%0d: got %0d want %0d", s, cycle_count, s == 16);
        end
      end
    end
  endtask

  task automatic test_illegal();
    int p_before, e_before;
    p_before = m_phase;
    e_before = m_err;
    step(1, 4'b0101, 0);
    n_checks++;
    if (illegal !== 1'b1 || valid !== 1'b0 || locked !== 1'b0 || strobe !== 8'd0 ||
        phase !== 3'(p_before) || err_count !== 8'(e_before + 1)) begin
      n_fail++;
      $display("FAIL illegal_inject: got il=%b v=%b lk=%b st=%h ph=%0d err=%0d want 1 0 0 00 %0d %0d",
               illegal, valid, locked, strobe, phase, err_count, p_before, e_before + 1);
    end
  endtask

  task automatic test_skip();
    int e_before;
    for (int s = 0; s < 11; s++) begin
      step(1, codes[s % 8], 0);
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL relock s=%0d: got %h want %h", s, dut_vec(), model_vec());
      end
    end
    n_checks++;
    if (locked !== 1'b1 || phase !== 3'd2) begin
      n_fail++;
      $display("FAIL skip_setup: got lk=%b ph=%0d want 1 2", locked, phase);
    end
    e_before = m_err;
    step(1, 4'b1110, 0);
    n_checks++;
    if (skip !== 1'b1 || valid !== 1'b1 || locked !== 1'b0 || phase !== 3'd5 ||
        err_count !== 8'(e_before + 1)) begin
      n_fail++;
      $display("FAIL skip_jump: got sk=%b v=%b lk=%b ph=%0d err=%0d want 1 1 0 5 %0d",
               skip, valid, locked, phase, err_count, e_before + 1);
    end
  endtask

  task automatic test_en_hold();
    int idx, r;
    test_reset();
    idx = 0;
    for (int i = 0; i < 100; i++) begin
      r = $urandom_range(0, 3);
      if (r == 0) step(0, 4'($urandom_range(0, 15)), 0);
      else if (r == 1) step(1, codes[idx], 0);
      else begin
        idx = (idx + 1) % 8;
        step(1, codes[idx], 0);
      end
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL en_hold i=%0d: got %h want %h", i, dut_vec(), model_vec());
      end
    end
    n_checks++;
    if (locked !== 1'b1 || err_count !== 8'd0 || skip !== 1'b0) begin
      n_fail++;
      $display("FAIL en_hold_lock: got lk=%b err=%0d sk=%b want 1 0 0", locked, err_count, skip);
    end
  endtask

  task automatic test_random();
    int r, e;
    logic [3:0] q;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      e = ($urandom_range(0, 3) != 0);
      if (r < 7) q = codes[(m_phase + 1) % 8];
      else if (r == 7) q = codes[m_phase];
      else if (r == 8) q = codes[$urandom_range(0, 7)];
      else q = 4'($urandom_range(0, 15));
      step(e[0], q, ($urandom_range(0, 15) == 0));
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL random i=%0d: got %h want %h", i, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) begin
      step(1, 4'b1010, 0);
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL saturate i=%0d: got %h want %h", i, dut_vec(), model_vec());
      end
    end
    n_checks++;
    if (err_count !== 8'd255) begin
      n_fail++;
      $display("FAIL err_saturate: got %0d want 255", err_count);
    end
    step(1, 4'b0101, 1);
    n_checks++;
    if (err_count !== 8'd0 || illegal !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_priority: got err=%0d il=%b want 0 1", err_count, illegal);
    end
  endtask

  task automatic test_async_reset();
    for (int s = 0; s < 9; s++) step(1, codes[s % 8], 0);
    n_checks++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL async_setup: got lk=%b want 1", locked);
    end
    #2 reset = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (dut_vec() !== 31'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %h want 0", dut_vec());
    end
    @(negedge clk) reset = 1'b1;
    step(1, 4'b1110, 0);
    n_checks++;
    if (skip !== 1'b0 || valid !== 1'b1 || phase !== 3'd5 || err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL post_reset_first: got sk=%b v=%b ph=%0d err=%0d want 0 1 5 0",
               skip, valid, phase, err_count);
    end
    step(1, 4'b1100, 0);
    n_checks++;
    if (dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL post_reset_step: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  initial begin
    reset = 1'b1; en = 0; q_in = 4'h0; clr_err = 0;
    model_reset();
    test_reset();
    test_walk_lock();
    test_illegal();
    test_skip();
    test_en_hold();
    test_random();
    test_saturate();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
